// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM with clear sequencer.
// The merge helper lives in a parameterised class so each data width gets its own copy.
package dp_ram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  virtual class dp_ram_fn #(parameter int DATA_W = 16);
    // Bytes with be set come from new_w, the rest keep old_w.
    static function logic [DATA_W-1:0] byte_merge(
      input logic [DATA_W-1:0]   old_w,
      input logic [DATA_W-1:0]   new_w,
      input logic [DATA_W/8-1:0] be
    );
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
    endfunction
  endclass

endpackage

// File: rtl/dp_ram_out_pipe.sv
// Read response pipeline: carries {valid, data} through RD_LAT register stages.
// Data registers only load on valid, so the output word holds between reads.
module dp_ram_out_pipe
  import dp_ram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $fatal(1, "dp_ram_out_pipe: RD_LAT must be 1 or 2");
  end

  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0][DATA_W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    if (in_valid) dat_d[0] = in_data;
    for (int s = 1; s < RD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      if (vld_q[s-1]) dat_d[s] = dat_q[s-1];
    end
  end

  // Reset flushes in-flight reads so they never surface as r_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/dp_ram_be_pipe.sv
// Single-clock RAM with one write and one read port, per-byte write enables,
// 1/2-cycle read latency, selectable collision mode and a post-reset clear sequencer.
module dp_ram_be_pipe
  import dp_ram_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int DEPTH    = 12,
  parameter  int RD_LAT   = 1,
  parameter  int WR_FIRST = 1,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              ready,
  output logic              addr_err,
  output clr_state_t        dbg_state
);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $fatal(1, "dp_ram_be_pipe: DATA_W must be a multiple of 8");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic              addr_err_q, addr_err_d;

  logic              wr_in_range, rd_in_range;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] wr_merged, rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Interface contract: ready is a level; wr_en/rd_en are sampled only while
  // ready is high, each accepted read yields exactly one r_valid pulse RD_LAT
  // edges later, and r_data holds its last value whenever r_valid is low.
  always_comb begin
    wr_in_range = (wr_addr <= LAST_ADDR);
    rd_in_range = (rd_addr <= LAST_ADDR);
    wr_acc      = ready_q && wr_en && wr_in_range;
    rd_acc      = ready_q && rd_en && rd_in_range;
    addr_err_d  = ready_q && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));
    wr_merged   = dp_ram_fn#(DATA_W)::byte_merge(mem_q[wr_addr], w_data, wr_be);
    rd_word     = mem_q[rd_addr];
    if (WR_FIRST != 0 && wr_acc && (wr_addr == rd_addr)) rd_word = wr_merged;
  end

  // The clear sequencer owns the write port until the scrub is done.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merged;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = READY;
          ready_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      READY: begin
        mem_we = wr_acc;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ready_q    <= ready_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  dp_ram_out_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_out_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (r_valid),
    .out_data  (r_data)
  );

  assign ready     = ready_q;
  assign addr_err  = addr_err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/dp_ram_be_pipe.md
Name: dp_ram_be_pipe

Overview:
- Parametrised successor of the current dual-port RAM: one write port and one read port, single clock.
- Adds per-byte write enables, selectable read latency of 1 or 2 cycles, and a selectable read-during-write collision mode.
- After reset, a clear state machine scrubs the whole array to zero and then raises ready.
- Drops into the same interface-driven SV environment as a drop-in upgrade, with the extra signals added to the interface.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- DEPTH, 12, number of words; need not be a power of two.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 only.
- WR_FIRST, 1, collision mode: 1 = write-first (bypass new data), 0 = read-old.
- Derived localparams (not overridable): ADDR_W = $clog2(DEPTH), BE_W = DATA_W/8.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- wr_be  in  BE_W  byte enables; bit i covers w_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- r_data  out  DATA_W  read data.
- r_valid  out  1  one-cycle pulse per accepted read, aligned with r_data.
- ready  out  1  high once the clear sequence has finished.
- addr_err  out  1  one-cycle pulse when an out-of-range address is requested.

Behaviour:
- Reset (rst=0, asynchronous):
  - r_data=0, r_valid=0, ready=0, addr_err=0.
  - Read pipeline flushed; FSM forced to CLEAR with clr_ptr=0.
  - Array contents are not reset directly; the FSM clears them.
- FSM state CLEAR:
  - Each posedge writes 0 to mem[clr_ptr] and increments clr_ptr.
  - On the write to DEPTH-1, the FSM moves to READY.
  - ready (registered) is 1 from the DEPTH-th posedge after rst deasserts.
- FSM state READY: terminal state, left only by reset.
- While ready=0:
  - wr_en and rd_en are ignored.
  - r_valid stays 0 and addr_err stays 0.
- Write (ready=1, wr_en=1, wr_addr<DEPTH):
  - At the posedge, for each i with wr_be[i]=1, mem[wr_addr] byte i is updated.
  - Bytes with wr_be[i]=0 are unchanged.
  - wr_be=0 is a legal no-op.
- Read (ready=1, rd_en=1, rd_addr<DEPTH):
  - RD_LAT=1: r_data and r_valid are registered at the next posedge.
  - RD_LAT=2: one additional output register stage, so the response appears 2 posedges after the request.
- Read throughput:
  - One read per cycle, back-to-back, no bubbles.
  - r_valid pulses exactly once per accepted read.
- r_data hold rule: r_data holds its last value when r_valid=0 (no zeroing between reads).
- Collision (read and write accepted on the same address, same cycle):
  - WR_FIRST=1: r_data = merged word (new byte where wr_be set, old byte elsewhere).
  - WR_FIRST=0: r_data = the pre-write word.
  - The write always commits.
- Simultaneous read and write to different addresses are fully independent.
- Out of range (addr >= DEPTH; only possible when DEPTH is not a power of two):
  - Out-of-range write: dropped, no array change.
  - Out-of-range read: dropped, no r_valid.
  - addr_err pulses for 1 cycle at the next posedge if either port is out of range. Both out of range in the same cycle gives a single pulse.
- Reset mid-operation:
  - In-flight reads are discarded; r_valid never asserts for them.
  - The FSM restarts CLEAR from address 0.
- Elaboration checks: DATA_W%8!=0 or RD_LAT not in {1,2} raises $fatal.

Decomposition:
- Package dp_ram_pkg:
  - typedef enum logic {CLEAR, READY} clr_state_t.
  - Function byte_merge(old, new, be), parametrised via the class/parameter scheme.
  - Constants for the legal RD_LAT range.
- Sub-module dp_ram_out_pipe:
  - Parametrised on DATA_W and RD_LAT.
  - Carries {valid, data} through 1 or 2 register stages with asynchronous flush on rst.
- Top:
  - Contains the array, write logic, collision mux, clear FSM and range checks.

Test Plan:
- Reset release, DEPTH=12:
  - ready=0 for 11 posedges, ready=1 at the 12th.
  - Reads of addresses 0..11 then return 0x0000.
- Byte-enable write:
  - Write 0xABCD with wr_be=11 to addr 3, then 0x1234 with wr_be=01 to addr 3.
  - Read addr 3 returns 0xAB34, r_valid 1 cycle later (RD_LAT=1) or 2 cycles later (RD_LAT=2).
- Collision on addr 5:
  - Setup: mem[5]=0x1111; same cycle write 0x2222 be=10 and read addr 5.
  - WR_FIRST=1 returns 0x2211; WR_FIRST=0 returns 0x1111.
  - Next read of addr 5 returns 0x2211 in both modes.
- Out of range:
  - Write 0xFFFF to addr 14: addr_err pulses once and the array is unchanged.
  - Read addr 13: addr_err pulses and r_valid stays 0.
- Streaming:
  - 12 back-to-back reads of 0..11 after 12 writes of data=addr*0x0101.
  - Gives 12 consecutive r_valid cycles with matching data.
- Reset mid-operation:
  - Pull rst low with 2 reads in flight (RD_LAT=2).
  - r_valid stays 0, ready drops immediately, and CLEAR reruns: ready returns 12 cycles after release and prior data reads back 0.
